// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: run enable from the consumer, pixel strobe, counters
// and sync/blank/fetch flags from the generator.
interface vga_timing_gen_if #(
    parameter int unsigned CW = 11
);
    logic          enable;
    logic          pix_en;
    logic [CW-1:0] h_count;
    logic [CW-1:0] v_count;
    logic          hs;
    logic          vs;
    logic          bright;
    logic          read;
    logic          line_start;
    logic          frame_start;

    modport master (
        input  enable,
        output pix_en, h_count, v_count, hs, vs, bright, read, line_start, frame_start
    );

    modport slave (
        output enable,
        input  pix_en, h_count, v_count, hs, vs, bright, read, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v position counters and
// registered sync/blank/fetch decode taken from the next-state counters.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          HS_POL    = 1'b0,
    parameter bit          VS_POL    = 1'b0,
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned READ_LEAD = 1,
    parameter int unsigned CW        = 11
) (
    input  logic             clk_50,
    input  logic             reset_n,
    vga_timing_gen_if.master vga
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned CW1     = CW + 1;
    localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0]  H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0]  V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW1-1:0] H_ACT_X  = CW1'(H_ACTIVE);
    localparam logic [CW1-1:0] V_ACT_X  = CW1'(V_ACTIVE);
    localparam logic [CW1-1:0] H_TOT_X  = CW1'(H_TOTAL);
    localparam logic [CW1-1:0] HS_BEG_X = CW1'(H_ACTIVE + H_FP);
    localparam logic [CW1-1:0] HS_END_X = CW1'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW1-1:0] VS_BEG_X = CW1'(V_ACTIVE + V_FP);
    localparam logic [CW1-1:0] VS_END_X = CW1'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW1-1:0] LEAD_X   = CW1'(READ_LEAD);

    logic [DW-1:0]  div_q;
    logic [DW-1:0]  div_nxt;
    logic [CW-1:0]  h_q;
    logic [CW-1:0]  v_q;
    logic [CW-1:0]  h_nxt;
    logic [CW-1:0]  v_nxt;
    logic           adv;
    logic           h_wrap;
    logic           v_wrap;

    logic [CW1-1:0] hx;
    logic [CW1-1:0] vx;
    logic [CW1-1:0] h_lead_raw;
    logic [CW1-1:0] h_lead;
    logic [CW-1:0]  v_lead;
    logic           lead_wrap;
    logic           hs_nxt;
    logic           vs_nxt;
    logic           bright_nxt;
    logic           read_nxt;

    logic           pix_en_q;
    logic           hs_q;
    logic           vs_q;
    logic           bright_q;
    logic           read_q;
    logic           line_start_q;
    logic           frame_start_q;

    // Divider parks on its last value until the strobe for it has been issued,
    // so a pixel is never skipped after reset or a pause.
    always_comb begin
        adv     = vga.enable && pix_en_q;
        div_nxt = div_q;
        if (vga.enable) begin
            if (div_q != DIV_LAST) begin
                div_nxt = div_q + DW'(1);
            end else if (pix_en_q) begin
                div_nxt = '0;
            end
        end
    end

    // Position counters step once per pixel strobe.
    always_comb begin
        h_nxt  = h_q;
        v_nxt  = v_q;
        h_wrap = 1'b0;
        v_wrap = 1'b0;
        if (adv) begin
            if (h_q == H_LAST) begin
                h_nxt  = '0;
                h_wrap = 1'b1;
                if (v_q == V_LAST) begin
                    v_nxt  = '0;
                    v_wrap = 1'b1;
                end else begin
                    v_nxt = v_q + CW'(1);
                end
            end else begin
                h_nxt = h_q + CW'(1);
            end
        end
    end

    // Sync and blank decode from the position the counters are about to take.
    always_comb begin
        hx         = {1'b0, h_nxt};
        vx         = {1'b0, v_nxt};
        bright_nxt = (hx < H_ACT_X) && (vx < V_ACT_X);
        hs_nxt     = ((hx >= HS_BEG_X) && (hx < HS_END_X)) ? HS_POL : ~HS_POL;
        vs_nxt     = ((vx >= VS_BEG_X) && (vx < VS_END_X)) ? VS_POL : ~VS_POL;
    end

    // Fetch request looks READ_LEAD pixels ahead, rolling into the next line.
    always_comb begin
        h_lead_raw = hx + LEAD_X;
        lead_wrap  = (h_lead_raw >= H_TOT_X);
        h_lead     = lead_wrap ? (h_lead_raw - H_TOT_X) : h_lead_raw;
        v_lead     = v_nxt;
        if (lead_wrap) begin
            v_lead = (v_nxt == V_LAST) ? '0 : (v_nxt + CW'(1));
        end
        read_nxt = (h_lead < H_ACT_X) && ({1'b0, v_lead} < V_ACT_X);
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            div_q         <= '0;
            h_q           <= '0;
            v_q           <= '0;
            pix_en_q      <= 1'b0;
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
            bright_q      <= 1'b0;
            read_q        <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (vga.enable) begin
            div_q         <= div_nxt;
            h_q           <= h_nxt;
            v_q           <= v_nxt;
            pix_en_q      <= (div_nxt == DIV_LAST);
            hs_q          <= hs_nxt;
            vs_q          <= vs_nxt;
            bright_q      <= bright_nxt;
            read_q        <= read_nxt;
            line_start_q  <= h_wrap;
            frame_start_q <= h_wrap && v_wrap;
        end else begin
            pix_en_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end
    end

    assign vga.pix_en      = pix_en_q;
    assign vga.h_count     = h_q;
    assign vga.v_count     = v_q;
    assign vga.hs          = hs_q;
    assign vga.vs          = vs_q;
    assign vga.bright      = bright_q;
    assign vga.read        = read_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing, a reduced raster
// for whole-frame behaviour, and a CLK_DIV=1 inverted-polarity raster.
`timescale 1ns/1ps
module tb_vga_timing_gen;
    logic clk_50 = 1'b0;
    always #10 clk_50 = ~clk_50;

    logic rst_a_n;
    logic rst_b_n;
    logic rst_c_n;

    vga_timing_gen_if #(.CW(11)) vif_a ();
    vga_timing_gen_if #(.CW(6))  vif_b ();
    vga_timing_gen_if #(.CW(4))  vif_c ();

    vga_timing_gen dut_a (
        .clk_50  (clk_50),
        .reset_n (rst_a_n),
        .vga     (vif_a)
    );

    // H 16/2/4/2 = 24, V 6/2/2/2 = 12, two clocks per pixel, lead 3
    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(6),  .V_FP(2), .V_SYNC(2), .V_BP(2),
        .READ_LEAD(3), .CW(6)
    ) dut_b (
        .clk_50  (clk_50),
        .reset_n (rst_b_n),
        .vga     (vif_b)
    );

    // H 8/1/2/1 = 12, V 4/1/1/1 = 7, one clock per pixel, active-high syncs
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .CW(4)
    ) dut_c (
        .clk_50  (clk_50),
        .reset_n (rst_c_n),
        .vga     (vif_c)
    );

    // {hs, vs, bright, read, pix_en, line_start, frame_start}
    logic [6:0] outs_a;
    logic [6:0] outs_b;
    logic [6:0] outs_c;
    assign outs_a = {vif_a.hs, vif_a.vs, vif_a.bright, vif_a.read,
                     vif_a.pix_en, vif_a.line_start, vif_a.frame_start};
    assign outs_b = {vif_b.hs, vif_b.vs, vif_b.bright, vif_b.read,
                     vif_b.pix_en, vif_b.line_start, vif_b.frame_start};
    assign outs_c = {vif_c.hs, vif_c.vs, vif_c.bright, vif_c.read,
                     vif_c.pix_en, vif_c.line_start, vif_c.frame_start};

    int n_checks;
    int n_fail;

    task automatic step();
        @(posedge clk_50);
        #1;
    endtask

    task automatic test_reset();
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        rst_c_n = 1'b0;
        vif_a.enable = 1'b1;
        vif_b.enable = 1'b1;
        vif_c.enable = 1'b1;
        repeat (3) step();
        n_checks++;
        if (vif_a.h_count !== 11'd0 || vif_a.v_count !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_pos_a: got h=%0d v=%0d expected h=0 v=0", vif_a.h_count, vif_a.v_count);
        end
        n_checks++;
        if (outs_a !== 7'b1100000) begin
            n_fail++;
            $display("FAIL reset_outs_a: got %b expected 1100000", outs_a);
        end
        n_checks++;
        if (vif_b.h_count !== 6'd0 || vif_b.v_count !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_pos_b: got h=%0d v=%0d expected h=0 v=0", vif_b.h_count, vif_b.v_count);
        end
        n_checks++;
        if (outs_b !== 7'b1100000) begin
            n_fail++;
            $display("FAIL reset_outs_b: got %b expected 1100000", outs_b);
        end
        n_checks++;
        if (vif_c.h_count !== 4'd0 || vif_c.v_count !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_pos_c: got h=%0d v=%0d expected h=0 v=0", vif_c.h_count, vif_c.v_count);
        end
        n_checks++;
        if (outs_c !== 7'b0000000) begin
            n_fail++;
            $display("FAIL reset_outs_c: got %b expected 0000000", outs_c);
        end
    endtask

    task automatic test_line();
        int p, h, v, hl, vl;
        logic [6:0] ev;
        rst_a_n = 1'b1;
        for (int k = 1; k <= 1602; k++) begin
            step();
            p  = k / 2;
            h  = p % 800;
            v  = p / 800;
            hl = h + 1;
            vl = v;
            if (hl >= 800) begin
                hl = hl - 800;
                vl = (v + 1) % 525;
            end
            ev = {!(h >= 656 && h < 752), !(v >= 490 && v < 492), (h < 640 && v < 480),
                  (hl < 640 && vl < 480), (k % 2 == 1), (k % 2 == 0 && h == 0), 1'b0};
            n_checks++;
            if (vif_a.h_count !== 11'(h) || vif_a.v_count !== 11'(v)) begin
                n_fail++;
                $display("FAIL line_pos k=%0d: got h=%0d v=%0d expected h=%0d v=%0d",
                         k, vif_a.h_count, vif_a.v_count, h, v);
            end
            n_checks++;
            if (outs_a !== ev) begin
                n_fail++;
                $display("FAIL line_outs k=%0d: got %b expected %b", k, outs_a, ev);
            end
        end
    endtask

    task automatic test_enable();
        int guard;
        int exp_h[4];
        logic [6:0] exp_o[4];
        exp_h = '{100, 101, 101, 102};
        exp_o = '{7'b1111100, 7'b1111000, 7'b1111100, 7'b1111000};
        guard = 0;
        while (vif_a.h_count !== 11'd100 && guard < 400) begin
            step();
            guard++;
        end
        n_checks++;
        if (vif_a.h_count !== 11'd100) begin
            n_fail++;
            $display("FAIL enable_reach: got h=%0d expected h=100 within 400 clk", vif_a.h_count);
        end
        vif_a.enable = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            n_checks++;
            if (vif_a.h_count !== 11'd100 || vif_a.v_count !== 11'd1 || outs_a !== 7'b1111000) begin
                n_fail++;
                $display("FAIL enable_hold i=%0d: got h=%0d v=%0d outs=%b expected h=100 v=1 outs=1111000",
                         i, vif_a.h_count, vif_a.v_count, outs_a);
            end
        end
        vif_a.enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (vif_a.h_count !== 11'(exp_h[i]) || outs_a !== exp_o[i]) begin
                n_fail++;
                $display("FAIL enable_resume i=%0d: got h=%0d outs=%b expected h=%0d outs=%b",
                         i, vif_a.h_count, outs_a, exp_h[i], exp_o[i]);
            end
        end
    endtask

    task automatic test_frame();
        int p, h, v, hl, vl, last_fs, n_fs, vmax;
        logic [6:0] ev;
        last_fs = 0;
        n_fs    = 0;
        vmax    = 0;
        rst_b_n = 1'b1;
        for (int k = 1; k <= 1200; k++) begin
            step();
            p  = k / 2;
            h  = p % 24;
            v  = (p / 24) % 12;
            hl = h + 3;
            vl = v;
            if (hl >= 24) begin
                hl = hl - 24;
                vl = (v + 1) % 12;
            end
            ev = {!(h >= 18 && h < 22), !(v >= 8 && v < 10), (h < 16 && v < 6),
                  (hl < 16 && vl < 6), (k % 2 == 1), (k % 2 == 0 && h == 0),
                  (k % 2 == 0 && h == 0 && v == 0)};
            n_checks++;
            if (vif_b.h_count !== 6'(h) || vif_b.v_count !== 6'(v)) begin
                n_fail++;
                $display("FAIL frame_pos k=%0d: got h=%0d v=%0d expected h=%0d v=%0d",
                         k, vif_b.h_count, vif_b.v_count, h, v);
            end
            n_checks++;
            if (outs_b !== ev) begin
                n_fail++;
                $display("FAIL frame_outs k=%0d: got %b expected %b", k, outs_b, ev);
            end
            if (int'(vif_b.v_count) > vmax) vmax = int'(vif_b.v_count);
            if (vif_b.frame_start === 1'b1) begin
                if (last_fs > 0) begin
                    n_checks++;
                    if (k - last_fs != 576) begin
                        n_fail++;
                        $display("FAIL frame_period: got %0d clk expected 576", k - last_fs);
                    end
                end
                last_fs = k;
                n_fs++;
            end
        end
        n_checks++;
        if (n_fs != 2) begin
            n_fail++;
            $display("FAIL frame_count: got %0d expected 2", n_fs);
        end
        n_checks++;
        if (vmax != 11) begin
            n_fail++;
            $display("FAIL frame_vmax: got %0d expected 11", vmax);
        end
    endtask

    task automatic test_mid_reset();
        int guard;
        guard = 0;
        while (!(vif_b.h_count === 6'd10 && vif_b.v_count === 6'd7) && guard < 400) begin
            step();
            guard++;
        end
        n_checks++;
        if (vif_b.h_count !== 6'd10 || vif_b.v_count !== 6'd7) begin
            n_fail++;
            $display("FAIL midrst_reach: got h=%0d v=%0d expected h=10 v=7", vif_b.h_count, vif_b.v_count);
        end
        #5;
        rst_b_n = 1'b0;
        #1;
        n_checks++;
        if (vif_b.h_count !== 6'd0 || vif_b.v_count !== 6'd0 || outs_b !== 7'b1100000) begin
            n_fail++;
            $display("FAIL midrst_async: got h=%0d v=%0d outs=%b expected h=0 v=0 outs=1100000",
                     vif_b.h_count, vif_b.v_count, outs_b);
        end
        step();
        n_checks++;
        if (vif_b.h_count !== 6'd0 || outs_b !== 7'b1100000) begin
            n_fail++;
            $display("FAIL midrst_held: got h=%0d outs=%b expected h=0 outs=1100000", vif_b.h_count, outs_b);
        end
        rst_b_n = 1'b1;
        step();
        n_checks++;
        if (vif_b.h_count !== 6'd0 || vif_b.v_count !== 6'd0 || outs_b !== 7'b1111100) begin
            n_fail++;
            $display("FAIL midrst_first: got h=%0d v=%0d outs=%b expected h=0 v=0 outs=1111100",
                     vif_b.h_count, vif_b.v_count, outs_b);
        end
        for (int j = 2; j <= 48; j++) begin
            step();
            if (j == 2) begin
                n_checks++;
                if (vif_b.h_count !== 6'd1 || vif_b.v_count !== 6'd0) begin
                    n_fail++;
                    $display("FAIL midrst_step: got h=%0d v=%0d expected h=1 v=0", vif_b.h_count, vif_b.v_count);
                end
            end
            if (j == 48) begin
                n_checks++;
                if (vif_b.h_count !== 6'd0 || vif_b.v_count !== 6'd1 || outs_b !== 7'b1111010) begin
                    n_fail++;
                    $display("FAIL midrst_line: got h=%0d v=%0d outs=%b expected h=0 v=1 outs=1111010",
                             vif_b.h_count, vif_b.v_count, outs_b);
                end
            end
        end
    endtask

    task automatic test_small();
        int p, h, v, hl, vl, last_fs, n_fs;
        logic [6:0] ev;
        last_fs = 0;
        n_fs    = 0;
        rst_c_n = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            step();
            p  = k - 1;
            h  = p % 12;
            v  = (p / 12) % 7;
            hl = h + 1;
            vl = v;
            if (hl >= 12) begin
                hl = hl - 12;
                vl = (v + 1) % 7;
            end
            ev = {(h >= 9 && h < 11), (v == 5), (h < 8 && v < 4), (hl < 8 && vl < 4),
                  1'b1, (p > 0 && h == 0), (p > 0 && h == 0 && v == 0)};
            n_checks++;
            if (vif_c.h_count !== 4'(h) || vif_c.v_count !== 4'(v)) begin
                n_fail++;
                $display("FAIL small_pos k=%0d: got h=%0d v=%0d expected h=%0d v=%0d",
                         k, vif_c.h_count, vif_c.v_count, h, v);
            end
            n_checks++;
            if (outs_c !== ev) begin
                n_fail++;
                $display("FAIL small_outs k=%0d: got %b expected %b", k, outs_c, ev);
            end
            if (vif_c.frame_start === 1'b1) begin
                if (last_fs > 0) begin
                    n_checks++;
                    if (k - last_fs != 84) begin
                        n_fail++;
                        $display("FAIL small_period: got %0d clk expected 84", k - last_fs);
                    end
                end
                last_fs = k;
                n_fs++;
            end
        end
        n_checks++;
        if (n_fs != 2) begin
            n_fail++;
            $display("FAIL small_count: got %0d frame pulses expected 2", n_fs);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_line();
        test_enable();
        test_frame();
        test_mid_reset();
        test_small();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded 1 ms");
        $fatal(1);
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters (name, default, meaning):
- H_ACTIVE 640 visible pixels per line
- H_FP 16 horizontal front porch
- H_SYNC 96 horizontal sync width
- H_BP 48 horizontal back porch
- V_ACTIVE 480 visible lines
- V_FP 10 vertical front porch
- V_SYNC 2 vertical sync width
- V_BP 33 vertical back porch
- HS_POL 0 hs asserted level
- VS_POL 0 vs asserted level
- CLK_DIV 2 clk_50 cycles per pixel
- READ_LEAD 1 pixel periods by which read precedes bright
- CW 11 counter width
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 Ports (name, direction, width, meaning):
- clk_50 in 1 system clock
- reset_n in 1 async active-low reset
- enable in 1 synchronous run enable
- pix_en out 1 pixel-rate strobe
- h_count out CW current column
- v_count out CW current line
- hs out 1 horizontal sync
- vs out 1 vertical sync
- bright out 1 active-video flag
- read out 1 early pixel-fetch request
- line_start out 1 new-line pulse
- frame_start out 1 new-frame pulse
REQ-004 Legality: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL (same sum) SHALL each be at most 2^CW; CLK_DIV ≥ 1; 0 ≤ READ_LEAD < H_TOTAL.

Function
REQ-005 Divider counts 0..CLK_DIV-1 while enable=1; pix_en=1 exactly in cycles where divider = CLK_DIV-1. CLK_DIV=1 gives pix_en=enable.
REQ-006 On pix_en, h_count increments; at H_TOTAL-1 it wraps to 0 and v_count increments; v_count wraps from V_TOTAL-1 to 0.
REQ-007 enable=0: divider, counters and all registered outputs hold; pix_en=0, line_start=0, frame_start=0.
REQ-008 All outputs are registered and decoded from next-state counters, so hs/vs/bright/read align with h_count/v_count in the same cycle.
REQ-009 bright=1 iff h_count<H_ACTIVE and v_count<V_ACTIVE.
REQ-010 hs=HS_POL iff H_ACTIVE+H_FP ≤ h_count < H_ACTIVE+H_FP+H_SYNC; else ~HS_POL.
REQ-011 vs=VS_POL iff V_ACTIVE+V_FP ≤ v_count < V_ACTIVE+V_FP+V_SYNC; else ~VS_POL. vs is level on the whole line, not offset within it.
REQ-012 read=bright evaluated at lead position: h_lead=(h_count+READ_LEAD) mod H_TOTAL; v_lead=v_count, or (v_count+1) mod V_TOTAL when h_lead wrapped. READ_LEAD=0 gives read=bright.
REQ-013 line_start is a one-cycle pulse in the first cycle h_count=0 following a wrap; frame_start is the same, additionally requiring v_count=0; both coincide at frame wrap.
REQ-014 Arithmetic is unsigned, CW bits; lead computation SHALL NOT overflow CW (use CW+1 internally).

Reset
REQ-015 reset_n=0 asynchronously forces: divider=0, h_count=0, v_count=0, hs=~HS_POL, vs=~VS_POL, bright=0, read=0, pix_en=0, line_start=0, frame_start=0.
REQ-016 First clock after release, outputs decode (0,0): bright=1, read per REQ-012. No line_start/frame_start pulse is issued for this first frame.
REQ-017 Reset mid-frame SHALL abort immediately, with no completion of the current line.

Verification
REQ-018 Defaults, release reset, run 1 line: pix_en every 2nd clk; bright=1 for h 0..639 at v=0; hs=0 for h 656..751; line_start at h wrap after 1600 clk.
REQ-019 Defaults, full frame: vs=0 for v 490..491 only; frame_start period exactly 840000 clk; v_count max 524.
REQ-020 READ_LEAD=1: read rises at h=799,v=524 (line 0 fetch) and falls at h=639. read never asserts for v_lead ≥ 480.
REQ-021 enable dropped at h=100 for 50 clk: counters and sync frozen, pix_en=0; on resume h_count continues 101, 102, ...
REQ-022 reset_n low at v=300,h=400 mid-cycle: outputs take REQ-015 values before the next clk edge; restart at (0,0).
REQ-023 CLK_DIV=1, HS_POL=1, VS_POL=1, H 8/1/2/1, V 4/1/1/1: H_TOTAL=12, V_TOTAL=7; hs=1 at h 9..10; vs=1 at v=5; frame every 84 clk.
